// File: rtl/ldpc_systematic_encoder_bpsk.sv
// Systematic (6,3) LDPC encoder (H = [P | I3]) with a BPSK map to IEEE-754 +/-1.0 symbols.
// Optional syndrome self-check is enabled with the macro LDPC_ENCODER_SYNDROME_CHECK_EN.
module ldpc_systematic_encoder_bpsk #(
    parameter logic [8:0]  P_MATRIX    = 9'b110_011_101,
    parameter int          FLOAT_WIDTH = 32,
    parameter logic [31:0] ONE_FLOAT   = 32'h3F800000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 message,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 codeword,
    output logic [6*FLOAT_WIDTH-1:0]   symbol_vector,
    output logic                       syndrome_error
);

    // Handshake: a word is transferred on a rising edge where out_valid and
    // out_ready are both high; out_valid then drops and the FSM returns to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENCODE = 3'd1,
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
        CHECK  = 3'd2,
`endif
        MAP    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] msg;      // msg[2]=m0, msg[0]=m2
    logic [2:0] parity;   // parity[r] = p_r
    logic [1:0] row;
    logic [5:0] word_next;
    logic [6*FLOAT_WIDTH-1:0] sym_next;

    // Row r of P starts at bit 8-3r; shifting it up to the MSBs avoids a variable index.
    function automatic logic row_parity(input logic [2:0] m, input logic [1:0] r);
        logic [8:0] sh;
        sh = P_MATRIX << (4'(r) * 4'd3);
        return (m[2] & sh[8]) ^ (m[1] & sh[7]) ^ (m[0] & sh[6]);
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = ENCODE;
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
            ENCODE: if (row == 2'd2) state_next = CHECK;
            CHECK:  if (row == 2'd2) state_next = MAP;
`else
            ENCODE: if (row == 2'd2) state_next = MAP;
`endif
            MAP:    state_next = HOLD;
            HOLD:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        word_next = {msg, parity[0], parity[1], parity[2]};
        sym_next  = '0;
        for (int i = 0; i < 6; i++) begin
            sym_next[i*FLOAT_WIDTH +: FLOAT_WIDTH] =
                {word_next[i] ^ ONE_FLOAT[FLOAT_WIDTH-1], ONE_FLOAT[FLOAT_WIDTH-2:0]};
        end
    end

`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
    logic syn_flag;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            msg           <= '0;
            parity        <= '0;
            row           <= '0;
            out_valid     <= 1'b0;
            codeword      <= '0;
            symbol_vector <= '0;
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
            syn_flag       <= 1'b0;
            syndrome_error <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        msg    <= message;
                        parity <= '0;
                        row    <= '0;
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
                        syn_flag <= 1'b0;
`endif
                    end
                end
                ENCODE: begin
                    parity[row] <= row_parity(msg, row);
                    row         <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                end
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
                CHECK: begin
                    syn_flag <= syn_flag | (parity[row] ^ row_parity(msg, row));
                    row      <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                end
`endif
                MAP: begin
                    codeword      <= word_next;
                    symbol_vector <= sym_next;
                    out_valid     <= 1'b1;
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
                    syndrome_error <= syn_flag;
`endif
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef LDPC_ENCODER_SYNDROME_CHECK_EN
    assign syndrome_error = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_systematic_encoder_bpsk.sv
// Directed bench for ldpc_systematic_encoder_bpsk; expected words and symbols are hand-computed.
module tb_ldpc_systematic_encoder_bpsk;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   message;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   codeword;
    logic [191:0] symbol_vector;
    logic         syndrome_error;

    int checks = 0;
    int fails  = 0;

`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 4;
`endif

    localparam logic [191:0] SYM_101110 = {32'hBF800000, 32'h3F800000, 32'hBF800000,
                                           32'hBF800000, 32'hBF800000, 32'h3F800000};
    localparam logic [191:0] SYM_010110 = {32'h3F800000, 32'hBF800000, 32'h3F800000,
                                           32'hBF800000, 32'hBF800000, 32'h3F800000};

    ldpc_systematic_encoder_bpsk dut (
        .clk(clk), .reset(reset), .start(start), .message(message),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .codeword(codeword), .symbol_vector(symbol_vector),
        .syndrome_error(syndrome_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises; n = -1 when the budget expires.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; message = 3'b000; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: busy=%b out_valid=%b required 0/0", i, busy, out_valid);
            end
        end
        checks++;
        if (codeword !== 6'b0) begin fails++; $display("FAIL reset_codeword: got %b required 000000", codeword); end
        checks++;
        if (symbol_vector !== 192'b0) begin fails++; $display("FAIL reset_symbols: got %h required 0", symbol_vector); end
        checks++;
        if (syndrome_error !== 1'b0) begin fails++; $display("FAIL reset_syndrome: got %b required 0", syndrome_error); end
    endtask

    task automatic test_basic();
        int n;
        message = 3'b101; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; message = 3'b010;  // must not affect the word in flight
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_valid(n);
        checks++;
        if (n != LAT) begin fails++; $display("FAIL basic_latency: got %0d required %0d", n, LAT); end
        checks++;
        if (codeword !== 6'b101110) begin fails++; $display("FAIL basic_codeword: got %b required 101110", codeword); end
        checks++;
        if (symbol_vector !== SYM_101110) begin fails++; $display("FAIL basic_symbols: got %h required %h", symbol_vector, SYM_101110); end
        checks++;
        if (syndrome_error !== 1'b0) begin fails++; $display("FAIL basic_syndrome: got %b required 0", syndrome_error); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_hold();
        int n;
        message = 3'b111; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n != LAT) begin fails++; $display("FAIL hold_latency: got %0d required %0d", n, LAT); end
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0); message = 3'b000;
            tick();
            checks++;
            if (out_valid !== 1'b1 || codeword !== 6'b111000) begin
                fails++;
                $display("FAIL hold_wait cycle %0d: out_valid=%b codeword=%b required 1/111000", i, out_valid, codeword);
            end
        end
        start = 1'b1; out_ready = 1'b1;  // start coinciding with the handshake edge
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || codeword !== 6'b111000) begin
            fails++;
            $display("FAIL hold_release: out_valid=%b busy=%b codeword=%b required 0/0/111000", out_valid, busy, codeword);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL hold_start_ignored: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        message = 3'b000; start = 1'b1; out_ready = 1'b1;
        tick();  // E0
        start = 1'b0;
        tick();  // E1
        reset = 1'b1;
        tick();  // E2
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || codeword !== 6'b0 || symbol_vector !== 192'b0 || syndrome_error !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: busy=%b out_valid=%b codeword=%b syn=%b required all 0",
                     busy, out_valid, codeword, syndrome_error);
        end
        message = 3'b011; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n != LAT || codeword !== 6'b011101) begin
            fails++;
            $display("FAIL midreset_reencode: latency=%0d codeword=%b required %0d/011101", n, codeword, LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0]   words[2];
        logic [191:0] sym2;
        int  nwords = 0;
        bit  idle_seen = 1'b0;
        bit  prev_valid = 1'b0;
        message = 3'b100; start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 60 && nwords < 2; i++) begin
            tick();
            if (out_valid === 1'b1 && !prev_valid) begin
                words[nwords] = codeword;
                if (nwords == 1) sym2 = symbol_vector;
                nwords++;
                message = 3'b010;
            end
            if (nwords == 1 && busy === 1'b0) idle_seen = 1'b1;
            prev_valid = (out_valid === 1'b1);
        end
        start = 1'b0;
        checks++;
        if (nwords != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d words required 2", nwords);
        end else begin
            checks++;
            if (words[0] !== 6'b100101) begin fails++; $display("FAIL b2b_word0: got %b required 100101", words[0]); end
            checks++;
            if (words[1] !== 6'b010110) begin fails++; $display("FAIL b2b_word1: got %b required 010110", words[1]); end
            checks++;
            if (sym2 !== SYM_010110) begin fails++; $display("FAIL b2b_symbols1: got %h required %h", sym2, SYM_010110); end
        end
        checks++;
        if (!idle_seen) begin fails++; $display("FAIL b2b_idle_gap: seen=%b required 1", idle_seen); end
        tick(); tick();
    endtask

`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
    task automatic test_syndrome();
        int n;
        message = 3'b101; start = 1'b1; out_ready = 1'b1;
        tick();  // E0
        start = 1'b0;
        tick(); tick(); tick();  // E1..E3, now in CHECK
        force dut.parity = 3'b001;  // p1 knocked to 0
        wait_valid(n);
        release dut.parity;
        checks++;
        if (n < 0 || syndrome_error !== 1'b1) begin
            fails++;
            $display("FAIL syndrome_flag: got %b required 1", syndrome_error);
        end
        tick();
        message = 3'b101; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n != LAT || syndrome_error !== 1'b0 || codeword !== 6'b101110) begin
            fails++;
            $display("FAIL syndrome_clear: syn=%b codeword=%b latency=%0d required 0/101110/%0d",
                     syndrome_error, codeword, n, LAT);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef LDPC_ENCODER_SYNDROME_CHECK_EN
        test_syndrome();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
